// File: rtl/result_collector.sv
// Captures a burst of up to DEPTH results from the compute core, then replays
// them in order over valid/ready. Flags short bursts and oversized requests.
module result_collector #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16,
   parameter int CNT_W  = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [31:0]       n,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_done,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              busy,
   output logic [CNT_W-1:0]  count,
   output logic              err_short,
   output logic              err_overflow
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DRAIN} state_t;

   state_t              r_state, w_state_nxt;
   logic [DATA_W-1:0]   r_buf [DEPTH];
   logic [CNT_W-1:0]    r_count, r_n_lat, r_rd_idx;
   logic [CNT_W-1:0]    w_cnt_inc, w_n_clip;
   logic [DATA_W-1:0]   r_out_data;
   logic                r_out_valid, r_out_last, r_err_short, r_err_overflow;
   logic                w_accept, w_wr, w_cap_full, w_xfer, w_load, w_drain_done;
   logic                w_busy;

   assign w_accept     = (r_state == S_IDLE) && start && (n != 32'd0);
   assign w_n_clip     = (n > 32'(DEPTH)) ? CNT_W'(DEPTH) : n[CNT_W-1:0];
   assign w_wr         = (r_state == S_CAPTURE) && in_valid;
   assign w_cnt_inc    = r_count + {{(CNT_W-1){1'b0}}, w_wr};
   assign w_cap_full   = (w_cnt_inc == r_n_lat);
   assign w_xfer       = r_out_valid && out_ready;
   // First DRAIN cycle has nothing presented yet; afterwards refill on each transfer.
   assign w_load       = (r_state == S_DRAIN) && (!r_out_valid || (w_xfer && !r_out_last));
   assign w_drain_done = (r_state == S_DRAIN) && w_xfer && r_out_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:    if (w_accept) w_state_nxt = S_CAPTURE;
         S_CAPTURE: begin
            if (w_cap_full)   w_state_nxt = S_DRAIN;
            else if (in_done) w_state_nxt = (w_cnt_inc == '0) ? S_IDLE : S_DRAIN;
         end
         S_DRAIN:   if (w_drain_done) w_state_nxt = S_IDLE;
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_busy = (r_state != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (w_wr) r_buf[r_count[AW-1:0]] <= in_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count        <= '0;
         r_n_lat        <= '0;
         r_rd_idx       <= '0;
         r_err_short    <= 1'b0;
         r_err_overflow <= 1'b0;
         r_out_valid    <= 1'b0;
         r_out_last     <= 1'b0;
         r_out_data     <= '0;
      end else begin
         if (w_accept) begin
            r_n_lat        <= w_n_clip;
            r_err_overflow <= (n > 32'(DEPTH));
            r_err_short    <= 1'b0;
            r_count        <= '0;
         end
         if (w_wr) r_count <= w_cnt_inc;
         if ((r_state == S_CAPTURE) && in_done && !w_cap_full) r_err_short <= 1'b1;
         if (r_state == S_CAPTURE) r_rd_idx <= '0;
         if (w_load) begin
            r_out_data  <= r_buf[r_rd_idx[AW-1:0]];
            r_out_last  <= (r_rd_idx == r_count - CNT_W'(1));
            r_out_valid <= 1'b1;
            r_rd_idx    <= r_rd_idx + CNT_W'(1);
         end else if (w_drain_done) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
         end
      end
   end

   assign out_valid    = r_out_valid;
   assign out_data     = r_out_data;
   assign out_last     = r_out_last;
   assign busy         = w_busy;
   assign count        = r_count;
   assign err_short    = r_err_short;
   assign err_overflow = r_err_overflow;

endmodule

// File: tb/tb_result_collector.sv
// Randomized scoreboard bench for result_collector: expected words are queued
// as stimulus is issued and a negedge monitor compares whatever the DUT presents.
module tb_result_collector;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 16;
   localparam int CNT_W  = 5;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [31:0]       n = '0;
   logic              in_valid = 1'b0;
   logic [DATA_W-1:0] in_data = '0;
   logic              in_done = 1'b0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [DATA_W-1:0] out_data;
   logic              out_last;
   logic              busy;
   logic [CNT_W-1:0]  count;
   logic              err_short;
   logic              err_overflow;

   result_collector #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .n(n),
      .in_valid(in_valid), .in_data(in_data), .in_done(in_done),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .busy(busy), .count(count),
      .err_short(err_short), .err_overflow(err_overflow)
   );

   always #5 clk = ~clk;

   typedef struct { logic [DATA_W-1:0] data; logic last; } exp_t;
   exp_t              sb[$];
   logic [DATA_W-1:0] stim[$];
   int                checks = 0;
   int                errors = 0;
   int                xfers  = 0;
   int                rmode  = 0;
   int                m_cnt = 0;
   bit                m_short = 0, m_ovf = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // out_ready: 0 = held high, 1 = alternating, 2 = random
   initial begin
      bit tog = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         tog = ~tog;
         case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = tog;
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
               chk("unexpected_out_valid", 64'(out_valid), 64'd0);
            end else begin
               chk("out_data", 64'(out_data), 64'(sb[0].data));
               chk("out_last", 64'(out_last), 64'(sb[0].last));
               if (out_ready) begin
                  void'(sb.pop_front());
                  xfers++;
               end
            end
         end
      end
   end

   task automatic wait_idle(input string name);
      int t = 0;
      while (busy && t < 300) begin tick(); t++; end
      chk({name, "_idle_timeout"}, 64'(busy), 64'd0);
   endtask

   // Runs one burst using stim[]; in_done follows the samples when use_done.
   task automatic burst(input int nreq, input bit use_done, input bit done_with_last,
                        input bit mid_start, input bit gaps);
      int nlat = (nreq > DEPTH) ? DEPTH : nreq;
      int ncap = (stim.size() < nlat) ? stim.size() : nlat;
      m_cnt   = ncap;
      m_short = use_done && (stim.size() < nlat);
      m_ovf   = (nreq > DEPTH);
      start = 1'b1; n = 32'(nreq);
      tick();
      start = 1'b0; n = '0;
      for (int i = 0; i < stim.size(); i++) begin
         if (gaps) repeat ($urandom_range(0, 2)) tick();
         if (i < ncap) sb.push_back('{data: stim[i], last: (i == ncap - 1)});
         in_valid = 1'b1; in_data = stim[i];
         if (use_done && done_with_last && i == stim.size() - 1) in_done = 1'b1;
         if (mid_start && i == 1) begin start = 1'b1; n = 32'd3; end
         tick();
         in_valid = 1'b0; in_done = 1'b0; start = 1'b0; n = '0;
      end
      if (use_done && !(done_with_last && stim.size() > 0)) begin
         in_done = 1'b1;
         tick();
         in_done = 1'b0;
      end
      wait_idle("burst");
      chk("count", 64'(count), 64'(m_cnt));
      chk("err_short", 64'(err_short), 64'(m_short));
      chk("err_overflow", 64'(err_overflow), 64'(m_ovf));
      chk("out_valid_after", 64'(out_valid), 64'd0);
      chk("sb_drained", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      #20000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int t;
      int nreq, nlat, nsamp;
      bit ud;
      repeat (3) tick();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_flags", 64'({err_short, err_overflow, out_last}), 64'd0);
      rst_n = 1'b1;
      tick();

      // Scenario 1: back-to-back drain
      rmode = 0;
      stim = '{280, 910, 1900, 3250};
      burst(4, 0, 0, 0, 0);
      // Scenario 2: alternating ready
      rmode = 1;
      burst(4, 0, 0, 0, 1);
      // Scenario 3: short burst
      rmode = 0;
      stim = '{280, 910};
      burst(4, 1, 0, 0, 0);
      // Scenario 4: oversized request, 17th sample dropped
      stim.delete();
      for (int i = 1; i <= 17; i++) stim.push_back(i);
      burst(20, 0, 0, 0, 0);
      // in_done on the same cycle as a sample, and an empty short burst
      stim = '{11, 22, 33};
      burst(6, 1, 1, 0, 0);
      stim.delete();
      burst(5, 1, 0, 0, 0);

      // Scenario 5: reset during drain
      stim = '{101, 102, 103, 104, 105, 106, 107, 108};
      rmode = 0;
      xfers = 0;
      burst_start_only();
      t = 0;
      while (xfers < 2 && t < 200) begin tick(); t++; end
      chk("reset_wait_xfers", 64'(xfers >= 2), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_out_valid", 64'(out_valid), 64'd0);
      chk("async_rst_busy", 64'(busy), 64'd0);
      chk("async_rst_count", 64'(count), 64'd0);
      chk("async_rst_last", 64'(out_last), 64'd0);
      sb.delete();
      tick();
      rst_n = 1'b1;
      tick();
      stim = '{7};
      burst(1, 0, 0, 0, 0);

      // Scenario 6: n=0 ignored; start during capture ignored
      start = 1'b1; n = '0;
      tick();
      start = 1'b0;
      repeat (2) tick();
      chk("n0_busy", 64'(busy), 64'd0);
      chk("n0_count", 64'(count), 64'(m_cnt));
      chk("n0_flags", 64'({err_short, err_overflow}), 64'({m_short, m_ovf}));
      stim = '{280, 910, 1900, 3250};
      burst(4, 0, 0, 1, 0);

      // Randomized bursts
      for (int k = 0; k < 25; k++) begin
         rmode = $urandom_range(0, 2);
         nreq  = $urandom_range(1, 20);
         nlat  = (nreq > DEPTH) ? DEPTH : nreq;
         ud    = 1'($urandom_range(0, 1));
         nsamp = ud ? $urandom_range(0, nlat) : nlat + $urandom_range(0, 2);
         stim.delete();
         for (int i = 0; i < nsamp; i++) stim.push_back($urandom);
         burst(nreq, ud, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Starts an 8-word burst from stim[] without waiting for the drain.
   task automatic burst_start_only();
      start = 1'b1; n = 32'd8;
      tick();
      start = 1'b0; n = '0;
      for (int i = 0; i < stim.size(); i++) begin
         sb.push_back('{data: stim[i], last: (i == stim.size() - 1)});
         in_valid = 1'b1; in_data = stim[i];
         tick();
      end
      in_valid = 1'b0;
   endtask

endmodule
